// File: rtl/mux_arb_pkg.sv
// Shared constants, state encoding and index helper for the round-robin mux arbiter.
// Optional feature macro used by the arbiter: ARB_LOCK_EN.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  // IDLE: output register empty; BUSY: output register holds a word
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Next requester index, wrapping 3 -> 0 through the natural 2-bit overflow
  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
    return idx + SEL_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, modulo NUM_REQ.
// Produces a one-hot winner, its index and an any-request flag.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [SEL_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [SEL_W-1:0]   winner_idx,
  output logic               any_req
);

  logic             found;
  logic [SEL_W-1:0] cand;

  // Scan ptr, ptr+1, ... and latch onto the first requester that is valid
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    cand       = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && req_valid[cand]) begin
        found         = 1'b1;
        winner_idx    = cand;
        winner[cand]  = 1'b1;
      end
    end
  end

  assign any_req = |req_valid;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Four-way round-robin arbiter feeding a registered 4:1 data mux with valid/ready output.
// Optional macro ARB_LOCK_EN: the requester at index sel holding req_lock keeps winning
// without advancing the round-robin pointer. Without it, req_lock is ignored.
module rr_mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [WIDTH-1:0]     req_data0,
  input  logic [WIDTH-1:0]     req_data1,
  input  logic [WIDTH-1:0]     req_data2,
  input  logic [WIDTH-1:0]     req_data3,
  input  logic [NUM_REQ-1:0]   req_lock,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [SEL_W-1:0]     sel,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready
);

  state_t             state;
  logic [SEL_W-1:0]   ptr;
  logic               open_slot;
  logic [NUM_REQ-1:0] pick_winner;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;
  logic               lock_win;
  logic               grant_any;
  logic [SEL_W-1:0]   gnt_idx;
  logic [WIDTH-1:0]   gnt_data;

  rr_pick u_pick (
    .req_valid  (req_valid),
    .ptr        (ptr),
    .winner     (pick_winner),
    .winner_idx (pick_idx),
    .any_req    (pick_any)
  );

  // The output register can take a new word when empty or when it drains this cycle
  assign open_slot = (state == IDLE) || out_ready;

`ifdef ARB_LOCK_EN
  assign lock_win = open_slot && req_valid[sel] && req_lock[sel];
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign lock_win    = 1'b0;
`endif

  assign grant_any = open_slot && (lock_win || pick_any);
  assign gnt_idx   = lock_win ? sel : pick_idx;

  // Grant pulse is forced low while reset is held, otherwise one-hot of the winner
  always_comb begin
    gnt = '0;
    if (reset_n && grant_any) begin
      gnt = lock_win ? (NUM_REQ'(1) << sel) : pick_winner;
    end
  end

  // 4:1 data mux steered by the winning index
  always_comb begin
    gnt_data = req_data0;
    case (gnt_idx)
      2'd0:    gnt_data = req_data0;
      2'd1:    gnt_data = req_data1;
      2'd2:    gnt_data = req_data2;
      default: gnt_data = req_data3;
    endcase
  end

  // Capture the granted word, advance the pointer past the winner, or drain to IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (grant_any) begin
      out_data  <= gnt_data;
      sel       <= gnt_idx;
      out_valid <= 1'b1;
      state     <= BUSY;
      if (!lock_win) begin
        ptr <= next_idx(gnt_idx);
      end
    end else if ((state == BUSY) && out_ready) begin
      out_valid <= 1'b0;
      state     <= IDLE;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural arbitration model. Lock scenario needs ARB_LOCK_EN.
module tb_rr_mux_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [3:0]       req_valid;
  logic [3:0]       req_lock;
  logic [WIDTH-1:0] rd [4];
  logic             out_ready;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;

  int total = 0;
  int bad   = 0;

  // Behavioural model: pointer, occupancy, held word, held index, last winner
  int               mptr;
  int               msel;
  int               mlast;
  bit               mbusy;
  logic [WIDTH-1:0] mdata;

  // Free-running clock, period 10
  always #5 clk = ~clk;

  rr_mux_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data0 (rd[0]),
    .req_data1 (rd[1]),
    .req_data2 (rd[2]),
    .req_data3 (rd[3]),
    .req_lock  (req_lock),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  function automatic bit lock_applies();
`ifdef ARB_LOCK_EN
    return req_valid[msel] && req_lock[msel];
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_winner();
    if (lock_applies()) return msel;
    for (int k = 0; k < 4; k++) begin
      if (req_valid[(mptr + k) % 4]) return (mptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_gnt();
    bit open = !mbusy || out_ready;
    int w = model_winner();
    if (!open || w < 0) return 4'b0000;
    return 4'(1 << w);
  endfunction

  task automatic model_reset();
    mptr  = 0;
    msel  = 0;
    mlast = -1;
    mbusy = 1'b0;
    mdata = '0;
  endtask

  task automatic tick();
    bit open;
    int w;
    bit lk;
    @(posedge clk);
    open  = !mbusy || out_ready;
    w     = model_winner();
    lk    = lock_applies();
    mlast = -1;
    if (open && w >= 0) begin
      mdata = rd[w];
      msel  = w;
      mbusy = 1'b1;
      mlast = w;
      if (!lk) mptr = (w + 1) % 4;
    end else if (mbusy && out_ready) begin
      mbusy = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    req_valid = 4'b0000;
    req_lock  = 4'b0000;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) rd[i] = '0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    req_valid = 4'b1111;
    out_ready = 1'b1;
    reset_n   = 1'b0;
    model_reset();
    #2;
    total++; if (gnt !== 4'b0000) begin bad++; $display("[TB] FAIL reset_gnt got=%b want=0000", gnt); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("[TB] FAIL reset_data got=%0d want=0", out_data); end
    total++; if (sel !== 2'd0) begin bad++; $display("[TB] FAIL reset_sel got=%0d want=0", sel); end
    @(negedge clk);
    req_valid = 4'b0000;
    reset_n   = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0010;
    rd[1]     = 151;
    out_ready = 1'b1;
    #1;
    total++; if (gnt !== exp_gnt()) begin bad++; $display("[TB] FAIL single_gnt got=%b want=%b", gnt, exp_gnt()); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid got=%b want=1", out_valid); end
    total++; if (out_data !== mdata) begin bad++; $display("[TB] FAIL single_data got=%0d want=%0d", out_data, mdata); end
    total++; if (sel !== 2'(msel)) begin bad++; $display("[TB] FAIL single_sel got=%0d want=%0d", sel, msel); end
    @(negedge clk);
    req_valid = 4'b0000;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    rd[0] = 0; rd[1] = 151; rd[2] = 56; rd[3] = 3;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      total++; if (gnt !== 4'(1 << order[n])) begin bad++; $display("[TB] FAIL rr_gnt step=%0d got=%b want=%b", n, gnt, 4'(1 << order[n])); end
      tick();
      total++; if (out_data !== mdata) begin bad++; $display("[TB] FAIL rr_data step=%0d got=%0d want=%0d", n, out_data, mdata); end
      @(negedge clk);
    end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0100;
    rd[2]     = 56;
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    req_valid = 4'b1111;
    rd[0] = $urandom; rd[1] = $urandom; rd[3] = $urandom;
    out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      #1;
      total++; if (gnt !== 4'b0000) begin bad++; $display("[TB] FAIL bp_gnt cyc=%0d got=%b want=0000", n, gnt); end
      tick();
      total++; if (out_data !== 56 || sel !== 2'd2 || out_valid !== 1'b1) begin
        bad++; $display("[TB] FAIL bp_hold cyc=%0d got data=%0d sel=%0d v=%b want data=56 sel=2 v=1", n, out_data, sel, out_valid);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    total++; if (gnt !== exp_gnt()) begin bad++; $display("[TB] FAIL bp_release got=%b want=%b", gnt, exp_gnt()); end
    tick();
    total++; if (out_data !== mdata) begin bad++; $display("[TB] FAIL bp_next_data got=%0d want=%0d", out_data, mdata); end
    @(negedge clk);
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    req_valid = 4'b0100;
    rd[2]     = $urandom;
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    req_valid = 4'b1001;
    rd[0] = $urandom; rd[3] = $urandom;
    #1;
    total++; if (gnt !== 4'b1000) begin bad++; $display("[TB] FAIL wrap_gnt3 got=%b want=1000", gnt); end
    tick();
    total++; if (out_data !== mdata || sel !== 2'd3) begin bad++; $display("[TB] FAIL wrap_data3 got=%0d/%0d want=%0d/3", out_data, sel, mdata); end
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    total++; if (gnt !== 4'b0001) begin bad++; $display("[TB] FAIL wrap_gnt0 got=%b want=0001", gnt); end
    tick();
    total++; if (out_data !== mdata || sel !== 2'd0) begin bad++; $display("[TB] FAIL wrap_data0 got=%0d/%0d want=%0d/0", out_data, sel, mdata); end
    @(negedge clk);
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_reset_busy();
    do_reset();
    req_valid = 4'b0010;
    rd[1]     = $urandom | 1;
    out_ready = 1'b0;
    tick();
    @(negedge clk);
    req_valid = 4'b0000;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== '0 || sel !== 2'd0) begin
      bad++; $display("[TB] FAIL rstbusy_clear got v=%b data=%0d sel=%0d want 0/0/0", out_valid, out_data, sel);
    end
    @(negedge clk);
    reset_n   = 1'b1;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    #1;
    total++; if (gnt !== 4'b0001) begin bad++; $display("[TB] FAIL rstbusy_gnt got=%b want=0001", gnt); end
    tick();
    total++; if (sel !== 2'd0 || out_data !== mdata) begin bad++; $display("[TB] FAIL rstbusy_sel got=%0d want=0", sel); end
    @(negedge clk);
    req_valid = 4'b0000;
    tick();
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    req_valid = 4'b0100;
    rd[2]     = $urandom;
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    req_valid = 4'b0110;
    req_lock  = 4'b0100;
    rd[1]     = $urandom;
    for (int n = 0; n < 3; n++) begin
      rd[2] = $urandom;
      #1;
      total++; if (gnt !== 4'b0100) begin bad++; $display("[TB] FAIL lock_gnt n=%0d got=%b want=0100", n, gnt); end
      tick();
      total++; if (sel !== 2'd2 || out_data !== mdata) begin bad++; $display("[TB] FAIL lock_sel n=%0d got=%0d want=2", n, sel); end
      @(negedge clk);
    end
    req_lock = 4'b0000;
    #1;
    total++; if (gnt !== 4'b0010) begin bad++; $display("[TB] FAIL lock_release got=%b want=0010", gnt); end
    tick();
    @(negedge clk);
    req_valid = 4'b0000;
    tick();
  endtask
`endif

  task automatic test_random();
    bit pend [4];
    do_reset();
    for (int i = 0; i < 4; i++) pend[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (mlast >= 0) pend[mlast] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom % 3 == 0)) begin
          pend[i] = 1'b1;
          rd[i]   = $urandom;
        end
        req_valid[i] = pend[i];
      end
`ifdef ARB_LOCK_EN
      req_lock = 4'($urandom);
`endif
      out_ready = ($urandom % 4) != 0;
      #1;
      total++; if (gnt !== exp_gnt()) begin bad++; $display("[TB] FAIL rand_gnt cyc=%0d got=%b want=%b", c, gnt, exp_gnt()); end
      tick();
      total++; if (out_valid !== mbusy || (mbusy && (out_data !== mdata || sel !== 2'(msel)))) begin
        bad++; $display("[TB] FAIL rand_out cyc=%0d got v=%b d=%0d s=%0d want v=%b d=%0d s=%0d", c, out_valid, out_data, sel, mbusy, mdata, msel);
      end
      @(negedge clk);
    end
    req_valid = 4'b0000;
    req_lock  = 4'b0000;
    tick();
  endtask

  // Run every scenario in order, then report
  initial begin
    reset_n   = 1'b1;
    req_valid = 4'b0000;
    req_lock  = 4'b0000;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) rd[i] = '0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_reset_busy();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
